uart_rx_os: RTL and testbench
=============================

// Module: uart_rx_os
// PURPOSE
//  Parametrised oversampling UART receiver; successor to the single-byte receiver.
//  Samples an asynchronous serial line at OS_RATE x baud and centres each sample mid-bit.
//  Supports configurable data width, parity and stop bits, and rejects false start bits.
//  Delivers each word with framing/parity status over a valid/ready handshake, flagging overrun.
//  Sits between the pad-side rx line and the byte-consumer logic; baud_tick comes from the shared baud generator.
// PARAMETERS
//  DATA_BITS  8   data bits per frame, 5..9, sent LSB first
//  OS_RATE    16  baud_tick pulses per bit period, even, >=8
//  PARITY     0   0=none, 1=odd, 2=even
//  STOP_BITS  1   stop bits expected, 1 or 2
// PORTS
//  clk         in   1          system clock, all logic on rising edge
//  rst         in   1          synchronous, active-high reset
//  baud_tick   in   1          one-clk pulse at OS_RATE x baud
//  rx          in   1          asynchronous serial input, idle high
//  dout        out  DATA_BITS  received word, stable while dout_valid=1
//  dout_valid  out  1          word available
//  dout_ready  in   1          consumer accepts word when dout_valid & dout_ready
//  frame_err   out  1          word's stop bit(s) sampled low; qualified by dout_valid
//  parity_err  out  1          parity mismatch; qualified by dout_valid; always 0 if PARITY=0
//  overrun     out  1          sticky: a completed frame was dropped
//  busy        out  1          1 whenever FSM is not IDLE
// BEHAVIOUR
//  rx passes through a 2-FF synchroniser (rx_s); both FFs reset to 1. All FSM/counter activity advances only on baud_tick.
//  Reset: FSM=IDLE, tick/bit counters=0, dout=0, dout_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0.
//  Reset mid-frame aborts the frame; nothing is delivered.
//  FSM states: IDLE, START, DATA, PAR, STOP, WAIT_HI.
//   IDLE:    on tick with rx_s=0 -> START, clear tick_cnt.
//   START:   at tick_cnt=OS_RATE/2-1, sample rx_s.
//            If 1 (glitch): -> IDLE, no output. If 0: clear tick_cnt, -> DATA.
//   DATA:    sample every OS_RATE ticks (mid-bit), shift in LSB first.
//            After DATA_BITS samples: -> PAR if PARITY!=0, else -> STOP.
//   PAR:     one mid-bit sample. parity_err_n = (xor(data)^sample) != (PARITY==1).
//   STOP:    STOP_BITS mid-bit samples. Any low sample sets ferr_n.
//            At the last sample, complete the frame (delivery rules below).
//            Then -> WAIT_HI if ferr_n, else -> IDLE.
//   WAIT_HI: stay until tick with rx_s=1, then -> IDLE. Handles break: no re-trigger on a held-low line.
//  Completion is mid-stop-bit, so back-to-back frames are received with no gap.
//  Delivery, evaluated on the clk after the completing tick (latency = 1 clk from that tick):
//   - dout_valid=0, or (dout_valid & dout_ready) that cycle: load dout, frame_err, parity_err; dout_valid=1.
//   - dout_valid=1 & !dout_ready: new frame discarded; overrun<=1; held dout/flags unchanged.
//  Handshake: dout_valid stays high until accepted; dout/flags must not change while valid & !ready.
//   On accept with no simultaneous completion, dout_valid<=0 next clk.
//  overrun clears on the next accepted transfer (dout_valid & dout_ready) or on rst.
//   Simultaneous accept + overrun event is impossible by the rules above.
//  baud_tick during rst is ignored. rx changes between ticks have no effect beyond the synchroniser.
// TESTING
//  1. Defaults, rx frame 0x55 (8N1) at 16x ticks, dout_ready=1 -> dout=0x55, dout_valid 1 clk, no error flags.
//  2. PARITY=2, send 0xA3 with parity bit 0 -> dout=0xA3, parity_err=0.
//     Same with parity bit 1 -> parity_err=1.
//  3. rx low for 5 ticks, then high -> busy pulses, returns IDLE, dout_valid stays 0.
//  4. Break: rx low 12 bit-times, then high -> one word 0x00 with frame_err=1.
//     No second word until the next real start bit.
//  5. dout_ready=0, send 0x11 then 0x22 back-to-back -> dout=0x11 held, overrun=1.
//     Raise dout_ready -> 0x11 accepted, overrun=0, 0x22 never delivered.
//  6. Assert rst during bit 4 of a frame -> all outputs 0 next clk.
//     Next full frame 0x7E received correctly.

Source files
------------

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: mid-bit sampling at OS_RATE x baud,
// configurable framing, valid/ready output with sticky overrun.
module uart_rx_os #(
    parameter int DATA_BITS = 8,
    parameter int OS_RATE   = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(OS_RATE);
    localparam logic [TW-1:0] T_HALF = TW'(OS_RATE / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(OS_RATE - 1);
    localparam logic [3:0] D_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] S_LAST = 4'(STOP_BITS - 1);
    localparam logic ODD = (PARITY == 1);
    localparam logic HAS_PAR = (PARITY != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        WAIT_HI
    } state_t;

    logic rx_m, rx_s;
    state_t state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [3:0] bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic ferr_q, ferr_d;
    logic perr_q, perr_d;
    logic done_q, done_d;
    logic mid;
    logic stop_low;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign mid = (tick_q == T_FULL);
    assign stop_low = ferr_q | ~rx_s;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        done_d  = 1'b0;
        if (baud_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        tick_d  = '0;
                        bit_d   = '0;
                        ferr_d  = 1'b0;
                        perr_d  = 1'b0;
                    end
                end
                START: begin
                    if (tick_q == T_HALF) begin
                        tick_d  = '0;
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (mid) begin
                        tick_d  = '0;
                        shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                        if (bit_q == D_LAST) begin
                            bit_d   = '0;
                            state_d = HAS_PAR ? PAR : STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                PAR: begin
                    if (mid) begin
                        tick_d  = '0;
                        perr_d  = ((^shreg_q) ^ rx_s) != ODD;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                STOP: begin
                    if (mid) begin
                        tick_d = '0;
                        ferr_d = stop_low;
                        if (bit_q == S_LAST) begin
                            bit_d   = '0;
                            done_d  = 1'b1;
                            // a low stop bit may be a break: wait for idle
                            state_d = stop_low ? WAIT_HI : IDLE;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            done_q  <= done_d;
        end
    end

    // shreg/flags stay put until the next frame's data, so loading
    // them one clk after completion is safe
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else if (done_q) begin
            if (!dout_valid || dout_ready) begin
                dout       <= shreg_q;
                frame_err  <= ferr_q;
                parity_err <= perr_q;
                dout_valid <= 1'b1;
                if (dout_valid) begin
                    overrun <= 1'b0;
                end
            end else begin
                overrun <= 1'b1;
            end
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: 8N1 instance and an even-parity
// instance, directed frames, glitch, break, overrun and reset cases.
module tb_uart_rx_os;

    localparam int OS = 16;

    logic clk = 1'b0;
    logic rst;
    logic baud_tick;

    logic rx_a, rdy_a;
    logic [7:0] dout_a;
    logic vld_a, fe_a, pe_a, ovr_a, busy_a;

    logic rx_b, rdy_b;
    logic [7:0] dout_b;
    logic vld_b, fe_b, pe_b, ovr_b, busy_b;

    int checks = 0;
    int errors = 0;
    int vcnt_a = 0;
    int vsnap;
    bit busy_seen_a = 1'b0;

    logic [9:0] qa[$];
    logic [9:0] qb[$];

    uart_rx_os u_a (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx_a),
        .dout(dout_a), .dout_valid(vld_a), .dout_ready(rdy_a),
        .frame_err(fe_a), .parity_err(pe_a), .overrun(ovr_a),
        .busy(busy_a)
    );

    uart_rx_os #(.PARITY(2)) u_b (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx_b),
        .dout(dout_b), .dout_valid(vld_b), .dout_ready(rdy_b),
        .frame_err(fe_b), .parity_err(pe_b), .overrun(ovr_b),
        .busy(busy_b)
    );

    always #5 clk = ~clk;

    initial begin
        baud_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (vld_a) vcnt_a++;
            if (busy_a) busy_seen_a = 1'b1;
            if (vld_a && rdy_a) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_word", {22'd0, fe_a, pe_a, dout_a}, 32'hFFFF);
                end else begin
                    e = qa.pop_front();
                    chk("a_word", {22'd0, fe_a, pe_a, dout_a}, {22'd0, e});
                end
            end
            if (vld_b && rdy_b) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_word", {22'd0, fe_b, pe_b, dout_b}, 32'hFFFF);
                end else begin
                    e = qb.pop_front();
                    chk("b_word", {22'd0, fe_b, pe_b, dout_b}, {22'd0, e});
                end
            end
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!baud_tick) @(posedge clk);
        end
    endtask

    task automatic drive_bit(input bit sel, input logic v, input int n);
        @(negedge clk);
        if (sel) rx_b = v;
        else rx_a = v;
        wait_ticks(n);
    endtask

    task automatic send(input bit sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) drive_bit(sel, bits[i], OS);
    endtask

    task automatic set_rdy_a(input logic v);
        @(posedge clk);
        #1 rdy_a = v;
    endtask

    initial begin
        rst = 1'b1;
        rx_a = 1'b1;
        rx_b = 1'b1;
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        fork
            monitor();
        join_none
        repeat (4) @(negedge clk);
        chk("reset_a", {dout_a, vld_a, fe_a, pe_a, ovr_a, busy_a}, 0);
        chk("reset_b", {dout_b, vld_b, fe_b, pe_b, ovr_b, busy_b}, 0);
        rst = 1'b0;
        drive_bit(0, 1'b1, OS);

        // 8N1 0x55
        vcnt_a = 0;
        qa.push_back({2'b00, 8'h55});
        send(0, {6'd0, 1'b1, 8'h55, 1'b0}, 10);
        repeat (8) @(negedge clk);
        chk("valid_one_clk", vcnt_a, 1);

        // even parity 0xA3: correct then wrong parity bit
        qb.push_back({2'b00, 8'hA3});
        send(1, {5'd0, 1'b1, 1'b0, 8'hA3, 1'b0}, 11);
        qb.push_back({2'b01, 8'hA3});
        send(1, {5'd0, 1'b1, 1'b1, 8'hA3, 1'b0}, 11);
        drive_bit(1, 1'b1, OS);

        // false start: 5 ticks low
        vsnap = vcnt_a;
        busy_seen_a = 1'b0;
        drive_bit(0, 1'b0, 5);
        drive_bit(0, 1'b1, 2 * OS);
        chk("glitch_busy_seen", {31'd0, busy_seen_a}, 1);
        chk("glitch_busy_idle", {31'd0, busy_a}, 0);
        chk("glitch_no_word", vcnt_a - vsnap, 0);

        // break: 12 bit times low
        vsnap = vcnt_a;
        qa.push_back({2'b10, 8'h00});
        drive_bit(0, 1'b0, 12 * OS);
        drive_bit(0, 1'b1, 3 * OS);
        chk("break_one_word", vcnt_a - vsnap, 1);
        chk("break_idle", {31'd0, busy_a}, 0);
        qa.push_back({2'b00, 8'h5A});
        send(0, {6'd0, 1'b1, 8'h5A, 1'b0}, 10);

        // overrun with back-to-back frames
        set_rdy_a(1'b0);
        qa.push_back({2'b00, 8'h11});
        send(0, {6'd0, 1'b1, 8'h11, 1'b0}, 10);
        send(0, {6'd0, 1'b1, 8'h22, 1'b0}, 10);
        repeat (4) @(negedge clk);
        chk("ovr_set", {31'd0, ovr_a}, 1);
        chk("ovr_held_dout", {24'd0, dout_a}, 32'h11);
        chk("ovr_held_valid", {31'd0, vld_a}, 1);
        set_rdy_a(1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("ovr_cleared", {31'd0, ovr_a}, 0);
        chk("accept_valid_low", {31'd0, vld_a}, 0);
        drive_bit(0, 1'b1, 2 * OS);

        // reset during bit 4
        drive_bit(0, 1'b0, OS);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b1, OS);
        drive_bit(0, 1'b0, OS / 2);
        chk("pre_rst_busy", {31'd0, busy_a}, 1);
        @(negedge clk);
        rx_a = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_outs", {dout_a, vld_a, fe_a, pe_a, ovr_a, busy_a}, 0);
        rst = 1'b0;
        drive_bit(0, 1'b1, 2 * OS);
        qa.push_back({2'b00, 8'h7E});
        send(0, {6'd0, 1'b1, 8'h7E, 1'b0}, 10);
        repeat (10) @(negedge clk);

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
